// File: rtl/timer_pkg.sv
// Shared register map, CTRL bit layout, mode codes and FSM state encoding
// for the memory-mapped countdown timer.
package timer_pkg;

   localparam logic [1:0] OFF_CTRL   = 2'd0;
   localparam logic [1:0] OFF_PRESET = 2'd1;
   localparam logic [1:0] OFF_COUNT  = 2'd2;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_MODE_HI = 2;
   localparam int CTRL_IM      = 3;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LOAD = 2'b01,
      CNT  = 2'b10,
      INT  = 2'b11
   } state_t;

endpackage

// File: rtl/timer_dev.sv
// Countdown timer with CTRL/PRESET/COUNT registers, one-shot and auto-reload
// modes, and a maskable interrupt request.
module timer_dev
   import timer_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sel,
   input  logic [1:0]       addr,
   input  logic             we,
   input  logic [CNT_W-1:0] wd,
   output logic [CNT_W-1:0] rd,
   output logic             irq
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [3:0]       ctrl;
   logic [CNT_W-1:0] preset;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;
   logic             irq_flag;
   state_t           state;
   state_t           state_nxt;

   logic       wr_ctrl;
   logic       wr_preset;
   logic       en;
   logic       im;
   logic [1:0] mode;
   logic       flag_set;
   logic       flag_clr;
   logic       en_clr;

   assign wr_ctrl   = sel && we && (addr == OFF_CTRL);
   assign wr_preset = sel && we && (addr == OFF_PRESET);
   assign en        = ctrl[CTRL_EN];
   assign im        = ctrl[CTRL_IM];
   assign mode      = ctrl[CTRL_MODE_HI:CTRL_MODE_LO];

   always_comb begin
      rd = '0;
      case (addr)
         OFF_CTRL:   rd = {{(CNT_W-4){1'b0}}, ctrl};
         OFF_PRESET: rd = preset;
         OFF_COUNT:  rd = count;
         default:    rd = '0;
      endcase
   end

   assign irq = irq_flag & im;

   // Next state plus the side effects each transition has on COUNT, EN and the flag.
   always_comb begin
      state_nxt = state;
      count_nxt = count;
      flag_set  = 1'b0;
      flag_clr  = 1'b0;
      en_clr    = 1'b0;
      case (state)
         IDLE: begin
            if (en) state_nxt = LOAD;
         end
         LOAD: begin
            count_nxt = preset;
            state_nxt = en ? CNT : IDLE;
         end
         CNT: begin
            if (!en) begin
               state_nxt = IDLE;
            end else if (count == '0) begin
               state_nxt = INT;
               flag_set  = 1'b1;
               en_clr    = (mode != MODE_RELOAD);
            end else begin
               count_nxt = count - ONE;
            end
         end
         INT: begin
            if (mode == MODE_RELOAD) begin
               state_nxt = LOAD;
               flag_clr  = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A bus write to CTRL overrides both the one-shot EN clear and the flag set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         ctrl     <= '0;
         preset   <= '0;
         count    <= '0;
         irq_flag <= 1'b0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         if (wr_preset) preset <= wd;
         if (wr_ctrl) begin
            ctrl <= wd[3:0];
         end else if (en_clr) begin
            ctrl[CTRL_EN] <= 1'b0;
         end
         if (wr_ctrl) begin
            irq_flag <= 1'b0;
         end else if (flag_set) begin
            irq_flag <= 1'b1;
         end else if (flag_clr) begin
            irq_flag <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: reset, one-shot, auto-reload, PRESET
// shadowing, CTRL-write priority and bus-decode corner cases.
`timescale 1ns/100ps
module tb_timer_dev;

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_PRESET = 2'd1;
   localparam logic [1:0] A_COUNT  = 2'd2;
   localparam logic [1:0] A_RSVD   = 2'd3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        sel = 1'b0;
   logic [1:0]  addr = 2'd0;
   logic        we = 1'b0;
   logic [31:0] wd = '0;
   logic [31:0] rd;
   logic        irq;

   int checks = 0;
   int errors = 0;

   timer_dev #(.CNT_W(32)) dut (
      .clk(clk), .reset(reset), .sel(sel), .addr(addr), .we(we),
      .wd(wd), .rd(rd), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drives one bus cycle from the falling edge so it lands on the next rising edge.
   task automatic applyStimulus(input logic s, input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      sel = s; we = 1'b1; addr = a; wd = d;
      @(posedge clk);
      #1;
      sel = 1'b0; we = 1'b0;
   endtask

   task automatic stepCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkReg(input string tag, input logic [1:0] a, input logic [31:0] exp);
      addr = a;
      #0.5;
      checkOutput(tag, rd, exp);
   endtask

   initial begin
      // Power-on reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      checkReg("por_ctrl", A_CTRL, 32'h0);
      checkReg("por_preset", A_PRESET, 32'h0);
      checkReg("por_count", A_COUNT, 32'h0);
      checkOutput("por_irq", {31'b0, irq}, 32'h0);

      // Reset asserted mid-count with COUNT=5
      applyStimulus(1'b1, A_PRESET, 32'd7);
      applyStimulus(1'b1, A_CTRL, 32'h9);
      stepCycles(4);
      checkReg("pre_rst_count", A_COUNT, 32'd5);
      #1;
      reset = 1'b0;
      checkReg("rst_count", A_COUNT, 32'h0);
      checkReg("rst_ctrl", A_CTRL, 32'h0);
      checkReg("rst_preset", A_PRESET, 32'h0);
      checkOutput("rst_irq", {31'b0, irq}, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      stepCycles(3);
      checkReg("post_rst_count", A_COUNT, 32'h0);
      checkReg("post_rst_ctrl", A_CTRL, 32'h0);

      // One-shot, PRESET=3
      applyStimulus(1'b1, A_PRESET, 32'd3);
      applyStimulus(1'b1, A_CTRL, 32'h9);
      stepCycles(2);
      checkReg("os_t2", A_COUNT, 32'd3);
      stepCycles(1);
      checkReg("os_t3", A_COUNT, 32'd2);
      stepCycles(1);
      checkReg("os_t4", A_COUNT, 32'd1);
      stepCycles(1);
      checkReg("os_t5", A_COUNT, 32'd0);
      checkOutput("os_t5_irq", {31'b0, irq}, 32'h0);
      stepCycles(1);
      checkOutput("os_t6_irq", {31'b0, irq}, 32'h1);
      checkReg("os_t6_ctrl", A_CTRL, 32'h8);
      stepCycles(3);
      checkOutput("os_hold_irq", {31'b0, irq}, 32'h1);
      checkReg("os_hold_count", A_COUNT, 32'd0);

      // CTRL write clears the sticky flag without restarting
      applyStimulus(1'b1, A_CTRL, 32'h8);
      checkOutput("clr_irq", {31'b0, irq}, 32'h0);
      stepCycles(3);
      checkOutput("clr_irq_hold", {31'b0, irq}, 32'h0);
      checkReg("clr_count", A_COUNT, 32'd0);
      checkReg("clr_ctrl", A_CTRL, 32'h8);

      // Auto-reload, PRESET=2: one-cycle irq every 5 cycles
      applyStimulus(1'b1, A_PRESET, 32'd2);
      applyStimulus(1'b1, A_CTRL, 32'hB);
      for (int i = 1; i <= 12; i++) begin
         stepCycles(1);
         checkOutput($sformatf("rl_irq_t%0d", i), {31'b0, irq}, (i == 5 || i == 10) ? 32'h1 : 32'h0);
         if (i == 7) checkReg("rl_count_t7", A_COUNT, 32'd2);
         if (i == 9) checkReg("rl_count_t9", A_COUNT, 32'd0);
      end
      checkReg("rl_ctrl", A_CTRL, 32'hB);
      applyStimulus(1'b1, A_CTRL, 32'h0);
      stepCycles(3);
      checkReg("rl_stop_count", A_COUNT, 32'd1);
      checkOutput("rl_stop_irq", {31'b0, irq}, 32'h0);

      // PRESET rewrite mid-count only affects the next LOAD
      applyStimulus(1'b1, A_PRESET, 32'd4);
      applyStimulus(1'b1, A_CTRL, 32'h1);
      stepCycles(2);
      checkReg("ps_t2", A_COUNT, 32'd4);
      stepCycles(1);
      checkReg("ps_t3", A_COUNT, 32'd3);
      applyStimulus(1'b1, A_PRESET, 32'd100);
      checkReg("ps_t4", A_COUNT, 32'd2);
      stepCycles(2);
      checkReg("ps_t6", A_COUNT, 32'd0);
      stepCycles(1);
      checkReg("ps_t7_ctrl", A_CTRL, 32'h0);
      checkReg("ps_t7_preset", A_PRESET, 32'd100);
      checkOutput("ps_t7_irq", {31'b0, irq}, 32'h0);
      applyStimulus(1'b1, A_CTRL, 32'h1);
      stepCycles(2);
      checkReg("ps_reload", A_COUNT, 32'd100);
      stepCycles(1);
      checkReg("ps_reload_dec", A_COUNT, 32'd99);

      // CTRL write on the same edge as INT entry: written EN wins
      applyStimulus(1'b1, A_CTRL, 32'h0);
      applyStimulus(1'b1, A_PRESET, 32'd2);
      applyStimulus(1'b1, A_CTRL, 32'h9);
      stepCycles(2);
      checkReg("pr_t2", A_COUNT, 32'd2);
      stepCycles(2);
      checkReg("pr_t4", A_COUNT, 32'd0);
      applyStimulus(1'b1, A_CTRL, 32'h1);
      checkReg("pr_t5_ctrl", A_CTRL, 32'h1);
      checkOutput("pr_t5_irq", {31'b0, irq}, 32'h0);
      stepCycles(3);
      checkReg("pr_restart", A_COUNT, 32'd2);
      stepCycles(3);
      checkReg("pr_t11_ctrl", A_CTRL, 32'h0);
      checkOutput("pr_t11_irq", {31'b0, irq}, 32'h0);

      // Bus decode corners
      applyStimulus(1'b0, A_PRESET, 32'd55);
      checkReg("nosel_preset", A_PRESET, 32'd2);
      applyStimulus(1'b1, A_COUNT, 32'd77);
      checkReg("ro_count", A_COUNT, 32'd0);
      applyStimulus(1'b1, A_RSVD, 32'hFFFF_FFFF);
      checkReg("rsvd_read", A_RSVD, 32'h0);
      applyStimulus(1'b1, A_CTRL, 32'hFFFF_FFF8);
      checkReg("ctrl_upper", A_CTRL, 32'h8);
      checkOutput("ctrl_wr_clears_flag", {31'b0, irq}, 32'h0);
      stepCycles(2);
      checkReg("idle_count", A_COUNT, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/timer_dev.md
Name: timer_dev

Overview:
Memory-mapped countdown timer on the processor bus, directly downstream of the CPU datapath's PrAddr/PrWD/PrWE outputs via the bridge's chip select.
- Returns read data to the bridge, which drives it onto PrRD.
- Its interrupt request drives one HWInt line into CP0.
- Three word registers: CTRL, PRESET and COUNT. Two counting modes: one-shot and auto-reload.

Parameters:
CNT_W, 32, width of PRESET/COUNT and of bus data.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
sel  input  1  chip select from bridge; qualifies we
addr  input  2  word offset (PrAddr[3:2])
we  input  1  write strobe; a write occurs when sel & we at a clk edge
wd  input  CNT_W  write data (PrWD)
rd  output  CNT_W  read data, combinational from addr
irq  output  1  interrupt request to HWInt

Behaviour:
- Register map (word offsets):
  - 0 CTRL: bits [3:0] used, upper bits read 0. [0] EN, [2:1] MODE, [3] IM.
  - 1 PRESET: read/write.
  - 2 COUNT: read-only; writes ignored.
  - 3 reserved: reads 0, writes ignored.
- Read path: rd = CTRL zero-extended / PRESET / COUNT / 0, selected by addr. Combinational, independent of sel.
- Reset (reset=0, asynchronous, immediate): CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0, irq=0, rd reflects the zeroed registers. Reset asserted mid-count aborts the count with no irq.
- FSM states: IDLE, LOAD, CNT, INT. 2-bit encoding from the package.
  - IDLE: if EN go LOAD, else stay.
  - LOAD: COUNT<=PRESET. If EN go CNT, else IDLE.
  - CNT: if !EN go IDLE (COUNT holds). Else if COUNT==0 go INT. Else COUNT<=COUNT-1.
  - INT:
    - MODE==01: go LOAD. irq_flag is 1 only while in INT (one-cycle pulse).
    - Any other MODE (00, 10, 11 = one-shot): EN is cleared on the edge entering INT, then go IDLE. irq_flag stays 1 until the next CTRL write.
- irq_flag is set on the edge entering INT.
- irq = irq_flag & IM, combinational. Clearing IM masks irq without clearing the flag.
- Latency: the write of EN=1 lands at edge t0. IDLE->LOAD at t1, COUNT=PRESET at t2. Then one decrement per cycle. INT is entered at edge t2+PRESET+1.
  - PRESET=0: INT at t3.
  - Count wraps never: decrement is gated at 0.
- Bus write to CTRL:
  - Clears irq_flag in the same edge.
  - Takes priority over the FSM's EN auto-clear in the same cycle: the written EN wins.
- PRESET write during CNT: does not affect COUNT until the next LOAD.
- EN=0 written in any state: the FSM returns to IDLE on the following edge, with COUNT frozen. INT still exits per its mode rule, with mode-1 reload aborted to IDLE via LOAD.
- Writes with sel=0 are ignored.
- MODE and IM may change mid-count; they take effect at their next use.

Decomposition:
- Shared package timer_pkg:
  - Register offsets: OFF_CTRL=0, OFF_PRESET=1, OFF_COUNT=2.
  - CTRL bit indices: EN=0, MODE=2:1, IM=3.
  - MODE codes: MODE_ONESHOT=00, MODE_RELOAD=01.
  - State encodings: IDLE=00, LOAD=01, CNT=10, INT=11.
- Single module. No sub-module is natural: register file and FSM share one write-priority rule and are kept together.

Test Plan:
- Reset with reset=0 mid-count (COUNT=5, state CNT) -> COUNT, CTRL and irq are 0 immediately, without waiting for clk; state IDLE after release.
- PRESET=3, CTRL=0x9 (EN, mode 0, IM) -> COUNT reads 3,2,1,0 on edges t2..t5. irq rises at t6 and stays high. CTRL reads 0x8. State IDLE.
- Continuing from the previous test, write CTRL=0x8 -> irq falls on that edge; no restart.
- PRESET=2, CTRL=0xB (mode 1) -> irq is a one-cycle pulse every 5 cycles (LOAD, 2, 1, 0, INT), repeating.
- During mode-0 counting, write PRESET=100 -> the current count still expires at the original time. The next EN=1 loads 100.
- In the same cycle the FSM enters INT (mode 0), write CTRL=0x1 -> EN stays 1 and irq_flag stays 0. The timer restarts via IDLE->LOAD with IM=0, so irq stays 0.
